// File: rtl/mmul_pkg.sv
// rtl/mmul_pkg.sv - shared sizes and state encoding for the 3x3 matrix unit feeder
package mmul_pkg;

  localparam int MMUL_DIM   = 3;
  localparam int MMUL_W     = 8;
  localparam int MMUL_VEC_W = MMUL_DIM * MMUL_DIM * MMUL_W;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_RESULT = 2'd2;

  typedef enum logic [1:0] {
    S_LOAD   = ST_LOAD,
    S_RUN    = ST_RUN,
    S_RESULT = ST_RESULT
  } state_e;

endpackage

// File: rtl/mmul_loader.sv
// rtl/mmul_loader.sv - packs A/B byte stream, drives mmul, returns its result with watchdog
module mmul_loader
  import mmul_pkg::*;
#(
  parameter int DIM     = MMUL_DIM,
  parameter int W       = MMUL_W,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W-1:0]         s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DIM*DIM*W-1:0] mat_a,
  output logic [DIM*DIM*W-1:0] mat_b,
  output logic                 enable,
  input  logic                 done,
  input  logic [DIM*DIM*W-1:0] mat_result,
  output logic [DIM*DIM*W-1:0] res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int N  = DIM * DIM;
  localparam int VW = N * W;
  localparam int CW = $clog2(2 * N);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] LAST_CNT  = CW'(2 * N - 1);
  localparam logic [CW-1:0] B_OFFSET  = CW'(N);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   el_idx;
  logic [VW-1:0]   mat_a_q, mat_a_d;
  logic [VW-1:0]   mat_b_q, mat_b_d;
  logic [VW-1:0]   res_q, res_d;
  logic            en_q, en_d;
  logic            rv_q, rv_d;
  logic            err_q, err_d;
  logic [WW-1:0]   wdog_q, wdog_d;

  // Next-state logic: byte packing in LOAD, done/watchdog in RUN, handshake in RESULT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    res_d   = res_q;
    en_d    = en_q;
    rv_d    = rv_q;
    err_d   = err_q;
    wdog_d  = wdog_q;
    el_idx  = (cnt_q < B_OFFSET) ? cnt_q : (cnt_q - B_OFFSET);

    case (state_q)
      S_LOAD: begin
        if (s_valid) begin
          if (cnt_q == '0) begin
            err_d = 1'b0;
          end
          if (cnt_q < B_OFFSET) begin
            mat_a_d[int'(el_idx)*W +: W] = s_data;
          end else begin
            mat_b_d[int'(el_idx)*W +: W] = s_data;
          end
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            wdog_d  = '0;
            en_d    = 1'b1;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        wdog_d = wdog_q + 1'b1;
        // done is checked first so a result arriving on the timeout cycle is kept
        if (done) begin
          res_d   = mat_result;
          en_d    = 1'b0;
          rv_d    = 1'b1;
          state_d = S_RESULT;
        end else if (wdog_q == WDOG_LAST) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_RESULT: begin
        // Only re-arm once mmul has dropped done, so a stale done cannot end the next run
        if (res_ready && !done) begin
          rv_d    = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // State and datapath registers; reset drops enable immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      res_q   <= '0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      res_q   <= res_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign s_ready   = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD) || (cnt_q != '0);
  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
  assign res_data  = res_q;
  assign enable    = en_q;
  assign res_valid = rv_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mmul_loader.sv
// tb/tb_mmul_loader.sv - directed table-driven bench for mmul_loader with an mmul stub
module tb_mmul_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [71:0] mat_a, mat_b, mat_result, res_data;
  logic        enable;
  logic        done = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy, err;

  logic        stub_hang = 1'b0;
  logic [2:0]  en_cnt = 3'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [71:0] a;
    logic [71:0] b;
    int          gap;
    logic [71:0] res;
  } vec_t;

  vec_t vt[4];

  mmul_loader #(.DIM(3), .W(8), .TIMEOUT(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .mat_a      (mat_a),
    .mat_b      (mat_b),
    .enable     (enable),
    .done       (done),
    .mat_result (mat_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy),
    .err        (err)
  );

  // Clock
  always #5 clk = ~clk;

  // mmul stub: done 4 cycles after enable rises, dropped 1 cycle after enable falls
  always @(posedge clk) begin
    if (enable) begin
      if (en_cnt != 3'd4) en_cnt <= en_cnt + 3'd1;
      if (en_cnt == 3'd3 && !stub_hang) done <= 1'b1;
    end else begin
      en_cnt <= 3'd0;
      done   <= 1'b0;
    end
  end

  // mmul stub result: per-element A+B mod 256
  always_comb begin
    mat_result = '0;
    for (int k = 0; k < 9; k++) mat_result[k*8 +: 8] = mat_a[k*8 +: 8] + mat_b[k*8 +: 8];
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input logic [71:0] a, input logic [71:0] b, input int gap);
    for (int k = 0; k < 18; k++) begin
      for (int g = 0; g < gap; g++) begin
        s_valid = 1'b0;
        s_data  = 8'hEE;
        step();
      end
      if (k == 17) chk1("enable_before_last", enable, 1'b0);
      s_valid = 1'b1;
      s_data  = (k < 9) ? a[k*8 +: 8] : b[(k-9)*8 +: 8];
      step();
    end
    s_valid = 1'b0;
    chk1("enable_after_last", enable, 1'b1);
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok && res_valid) ok = 1'b1;
      if (!ok) step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!ok && !busy) ok = 1'b1;
      if (!ok) step();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mat_a"}, mat_a, 72'h0);
    chk({tag, "_mat_b"}, mat_b, 72'h0);
    chk({tag, "_res_data"}, res_data, 72'h0);
    chk1({tag, "_enable"}, enable, 1'b0);
    chk1({tag, "_res_valid"}, res_valid, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_s_ready"}, s_ready, 1'b1);
  endtask

  initial begin
    bit ok;
    int n;

    vt[0] = '{a: 72'h010203010005030802, b: 72'h000003050601020008, gap: 0,
              res: 72'h01020606060605080A};
    vt[1] = '{a: 72'hFFFFFFFFFFFFFFFFFF, b: 72'h090807060504030201, gap: 0,
              res: 72'h080706050403020100};
    vt[2] = '{a: 72'h5A50463C32281E140A, b: 72'h505050505050505050, gap: 1,
              res: 72'hAAA0968C82786E645A};
    vt[3] = '{a: 72'h010203010005030802, b: 72'h000003050601020008, gap: 2,
              res: 72'h01020606060605080A};

    // Reset state, during and after reset
    #2;
    check_zero("rst_held");
    #10;
    reset = 1'b0;
    step();
    check_zero("rst_rel");

    // Table: stream, pack, run, result handshake, return to idle
    res_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      stream(vt[v].a, vt[v].b, vt[v].gap);
      chk($sformatf("v%0d_mat_a", v), mat_a, vt[v].a);
      chk($sformatf("v%0d_mat_b", v), mat_b, vt[v].b);
      chk1($sformatf("v%0d_busy_run", v), busy, 1'b1);
      chk1($sformatf("v%0d_s_ready_run", v), s_ready, 1'b0);
      wait_res(ok);
      chk1($sformatf("v%0d_res_valid_seen", v), ok, 1'b1);
      chk($sformatf("v%0d_res_data", v), res_data, vt[v].res);
      chk1($sformatf("v%0d_enable_result", v), enable, 1'b0);
      wait_idle(ok);
      chk1($sformatf("v%0d_idle_seen", v), ok, 1'b1);
      chk1($sformatf("v%0d_res_valid_after", v), res_valid, 1'b0);
      chk1($sformatf("v%0d_s_ready_after", v), s_ready, 1'b1);
      chk($sformatf("v%0d_res_held", v), res_data, vt[v].res);
    end

    // Consumer stalls: result held, no byte accepted
    res_ready = 1'b0;
    stream(vt[0].a, vt[0].b, 0);
    wait_res(ok);
    chk1("stall_res_valid_seen", ok, 1'b1);
    s_valid = 1'b1;
    s_data  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      chk1("stall_res_valid", res_valid, 1'b1);
      chk("stall_res_data", res_data, vt[0].res);
      chk1("stall_s_ready", s_ready, 1'b0);
      step();
    end
    s_valid   = 1'b0;
    res_ready = 1'b1;
    wait_idle(ok);
    chk1("stall_idle_seen", ok, 1'b1);
    chk("stall_mat_a_kept", mat_a, vt[0].a);
    chk("stall_mat_b_kept", mat_b, vt[0].b);

    // Watchdog: done never comes
    stub_hang = 1'b1;
    stream(vt[1].a, vt[1].b, 0);
    n = 0;
    while (enable && n < 400) begin
      n++;
      step();
    end
    chki("wdog_enable_cycles", n, 255);
    chk1("wdog_err", err, 1'b1);
    chk1("wdog_s_ready", s_ready, 1'b1);
    chk1("wdog_res_valid", res_valid, 1'b0);
    chk1("wdog_busy", busy, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h11;
    step();
    s_valid = 1'b0;
    chk1("wdog_err_cleared", err, 1'b0);
    chk1("wdog_busy_after_byte", busy, 1'b1);
    step();
    chk1("wdog_err_stays_clear", err, 1'b0);

    // Reset asserted in RUN: enable drops without a clock edge
    stub_hang = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    check_zero("pre_run");
    stream(vt[2].a, vt[2].b, 0);
    step();
    chk1("midrun_enable_before", enable, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("midrun_enable_async", enable, 1'b0);
    check_zero("midrun_rst");
    #2;
    reset = 1'b0;
    step();
    check_zero("midrun_rel");
    step();
    check_zero("midrun_rel2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
